// File: rtl/lcd_pkg.sv
// Shared HD44780 constants and the read/write controller state encoding.
// Pure definitions: no latency, no flow control.
package lcd_pkg;

    typedef logic [1:0] lcd_state_t;

    localparam lcd_state_t IDLE  = 2'd0;
    localparam lcd_state_t SETUP = 2'd1;
    localparam lcd_state_t ENH   = 2'd2;
    localparam lcd_state_t HOLD  = 2'd3;

    localparam int   LCD_BF_BIT    = 7;
    localparam logic LCD_RS_STATUS = 1'b0;
    localparam logic LCD_RS_DATA   = 1'b1;

endpackage

// File: rtl/lcd_read_controller.sv
// HD44780 read cycle (status or data), optionally polling the busy flag up to POLL_MAX reads.
// oDone after N*(CLK_Divide+EN_Low+2) cycles; starts are edge-triggered and dropped while busy.
module lcd_read_controller
    import lcd_pkg::*;
#(
    parameter int CLK_Divide = 1,
    parameter int EN_Low     = 2,
    parameter int POLL_MAX   = 16
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iStart,
    input  logic       iRS,
    input  logic       iPoll,
    output logic       oDone,
    output logic [7:0] oDATA,
    output logic       oTimeout,
    input  logic [7:0] LCD_DATA,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_RS
);

    localparam logic [15:0] EN_HI_LAST = 16'(CLK_Divide);
    localparam logic [15:0] EN_LO_LAST = 16'(EN_Low - 1);
    localparam logic [15:0] POLL_LIMIT = 16'(POLL_MAX);

    lcd_state_t  state_q;
    logic        pre_start_q;
    logic [15:0] cont_q;
    logic [15:0] hcont_q;
    logic [15:0] poll_cnt_q;
    logic        poll_q;
    logic        done_q;
    logic        timeout_q;
    logic        rw_q;
    logic        en_q;
    logic        rs_q;
    logic [7:0]  data_q;

    logic start_d;
    logic poll_more_d;

    assign start_d     = iStart & ~pre_start_q;
    // Another status read only while busy is still set and the read budget remains.
    assign poll_more_d = poll_q & data_q[LCD_BF_BIT] & (poll_cnt_q < POLL_LIMIT);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q     <= IDLE;
            pre_start_q <= 1'b0;
            cont_q      <= '0;
            hcont_q     <= '0;
            poll_cnt_q  <= '0;
            poll_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            rw_q        <= 1'b0;
            en_q        <= 1'b0;
            rs_q        <= 1'b0;
            data_q      <= '0;
        end else begin
            pre_start_q <= iStart;
            case (state_q)
                IDLE: begin
                    if (start_d) begin
                        done_q     <= 1'b0;
                        timeout_q  <= 1'b0;
                        rs_q       <= iRS;
                        poll_q     <= iPoll & (iRS == LCD_RS_STATUS);
                        rw_q       <= 1'b1;
                        poll_cnt_q <= '0;
                        state_q    <= SETUP;
                    end
                end
                SETUP: begin
                    en_q    <= 1'b1;
                    cont_q  <= '0;
                    state_q <= ENH;
                end
                ENH: begin
                    if (cont_q < EN_HI_LAST) begin
                        cont_q <= cont_q + 16'd1;
                    end else begin
                        // Bus is sampled on the same edge that drops EN.
                        data_q     <= LCD_DATA;
                        en_q       <= 1'b0;
                        poll_cnt_q <= poll_cnt_q + 16'd1;
                        hcont_q    <= '0;
                        state_q    <= HOLD;
                    end
                end
                HOLD: begin
                    if (hcont_q < EN_LO_LAST) begin
                        hcont_q <= hcont_q + 16'd1;
                    end else if (poll_more_d) begin
                        state_q <= SETUP;
                    end else begin
                        state_q   <= IDLE;
                        rw_q      <= 1'b0;
                        done_q    <= 1'b1;
                        timeout_q <= poll_q & data_q[LCD_BF_BIT];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign oDone    = done_q;
    assign oDATA    = data_q;
    assign oTimeout = timeout_q;
    assign LCD_RW   = rw_q;
    assign LCD_EN   = en_q;
    assign LCD_RS   = rs_q;

endmodule

// File: tb/tb_lcd_read_controller.sv
// Directed bench for lcd_read_controller: phase-arithmetic reference model compared every cycle,
// plus hand-computed latency, pulse-count and data expectations per scenario.
module tb_lcd_read_controller;

    localparam int CD = 1;
    localparam int EL = 2;
    localparam int PM = 4;
    localparam int T  = CD + EL + 2;

    logic       iCLK   = 1'b0;
    logic       iRST_N = 1'b1;
    logic       iStart = 1'b0;
    logic       iRS    = 1'b0;
    logic       iPoll  = 1'b0;
    logic [7:0] LCD_DATA = 8'h00;
    logic       oDone, oTimeout, LCD_RW, LCD_EN, LCD_RS;
    logic [7:0] oDATA;

    int checks = 0;
    int errors = 0;

    lcd_read_controller #(.CLK_Divide(CD), .EN_Low(EL), .POLL_MAX(PM)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iStart(iStart), .iRS(iRS), .iPoll(iPoll),
        .oDone(oDone), .oDATA(oDATA), .oTimeout(oTimeout), .LCD_DATA(LCD_DATA),
        .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .LCD_RS(LCD_RS)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a transaction is a run of reads of T cycles each, counted from the accept edge.
    int         cyc, m_acc, m_reads, r, ph;
    bit         m_busy, m_poll;
    logic       m_pre;
    logic [7:0] m_data;
    logic       m_rs, m_done, m_to, m_rw, m_en;

    always @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            cyc = 0; m_acc = 0; m_reads = 0; m_busy = 0; m_poll = 0; m_pre = 0;
            m_data = 8'h00; m_rs = 0; m_done = 0; m_to = 0; m_rw = 0; m_en = 0;
        end else begin
            cyc++;
            if (m_busy) begin
                r  = cyc - m_acc;
                ph = r % T;
                m_en = (ph >= 1 && ph <= CD + 1);
                if (ph == CD + 2) begin
                    m_data = LCD_DATA;
                    m_reads++;
                end
                if (ph == 0 && !(m_poll && m_data[7] && m_reads < PM)) begin
                    m_busy = 0; m_rw = 0; m_done = 1; m_to = m_poll & m_data[7];
                end
            end else if (iStart && !m_pre) begin
                m_busy = 1; m_acc = cyc; m_reads = 0;
                m_rs = iRS; m_poll = iPoll & ~iRS;
                m_rw = 1; m_done = 0; m_to = 0;
            end
            m_pre = iStart;
        end
    end

    always @(negedge iCLK) begin
        chk("cyc_oDone",    oDone,    m_done);
        chk("cyc_oDATA",    oDATA,    m_data);
        chk("cyc_oTimeout", oTimeout, m_to);
        chk("cyc_LCD_RW",   LCD_RW,   m_rw);
        chk("cyc_LCD_EN",   LCD_EN,   m_en);
        chk("cyc_LCD_RS",   LCD_RS,   m_rs);
    end

    // mode 0: plain pulse; 1: extra start edge and iRS/iPoll flips mid-flight; 2: iStart held high.
    task automatic run_txn(input logic rs, input logic poll, input int mode,
                           input logic [7:0] d_early, input logic [7:0] d_late, input int switch_after,
                           output int lat, output int pulses, output int enh,
                           output int first_rise, output int last_rise);
        int   k, falls;
        logic prev_en;
        lat = -1; pulses = 0; enh = 0; first_rise = -1; last_rise = -1;
        k = 0; falls = 0; prev_en = 1'b0;
        @(negedge iCLK);
        LCD_DATA = d_early; iRS = rs; iPoll = poll; iStart = 1'b1;
        while (k < 200) begin
            @(negedge iCLK);
            k++;
            if (LCD_EN && !prev_en) begin
                pulses++;
                if (first_rise < 0) first_rise = k - 1;
                last_rise = k - 1;
            end
            if (!LCD_EN && prev_en) begin
                falls++;
                if (falls == switch_after) LCD_DATA = d_late;
            end
            if (LCD_EN) enh++;
            prev_en = LCD_EN;
            if (k == 1) begin
                chk("accept_rw", LCD_RW, 1'b1);
                chk("accept_rs", LCD_RS, rs);
                if (mode != 2) iStart = 1'b0;
            end
            if (mode == 1) begin
                if (k == 2) begin iRS = ~rs; iPoll = ~poll; end
                if (k == 3) iStart = 1'b1;
                if (k == 4) iStart = 1'b0;
            end
            if (oDone) begin
                lat = k - 1;
                break;
            end
        end
    endtask

    int lat, pulses, enh, fr, lr;

    initial begin
        #1 iRST_N = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge iCLK);
            iStart = 1'($urandom); iRS = 1'($urandom); iPoll = 1'($urandom);
            LCD_DATA = 8'($urandom);
        end
        chk("rst_oDone", oDone, 1'b0);
        chk("rst_oDATA", oDATA, 8'h00);
        chk("rst_oTimeout", oTimeout, 1'b0);
        chk("rst_LCD_RW", LCD_RW, 1'b0);
        chk("rst_LCD_EN", LCD_EN, 1'b0);
        chk("rst_LCD_RS", LCD_RS, 1'b0);
        iStart = 1'b0; iRS = 1'b0; iPoll = 1'b0;
        iRST_N = 1'b1;
        @(negedge iCLK);

        // Single data read
        run_txn(1'b1, 1'b0, 0, 8'hA5, 8'hA5, 0, lat, pulses, enh, fr, lr);
        chk("single_latency", lat, 5);
        chk("single_pulses", pulses, 1);
        chk("single_en_high", enh, 2);
        chk("single_first_rise", fr, 1);
        chk("single_data", oDATA, 8'hA5);
        chk("single_timeout", oTimeout, 1'b0);
        chk("single_rw_low", LCD_RW, 1'b0);

        // Poll success: busy for two reads, then clear
        run_txn(1'b0, 1'b1, 0, 8'h80, 8'h23, 2, lat, pulses, enh, fr, lr);
        chk("poll_latency", lat, 15);
        chk("poll_pulses", pulses, 3);
        chk("poll_en_high", enh, 6);
        chk("poll_spacing", lr - fr, 10);
        chk("poll_data", oDATA, 8'h23);
        chk("poll_timeout", oTimeout, 1'b0);

        // Poll timeout: busy never clears
        run_txn(1'b0, 1'b1, 0, 8'h80, 8'h80, 0, lat, pulses, enh, fr, lr);
        chk("tmo_latency", lat, 20);
        chk("tmo_pulses", pulses, 4);
        chk("tmo_spacing", lr - fr, 15);
        chk("tmo_data", oDATA, 8'h80);
        chk("tmo_timeout", oTimeout, 1'b1);

        // Extra start edge and input flips during the read are ignored
        run_txn(1'b1, 1'b0, 1, 8'hC3, 8'hC3, 0, lat, pulses, enh, fr, lr);
        chk("ign_latency", lat, 5);
        chk("ign_pulses", pulses, 1);
        chk("ign_data", oDATA, 8'hC3);
        iRS = 1'b0; iPoll = 1'b0;
        repeat (10) @(negedge iCLK);
        chk("ign_no_retrigger_rw", LCD_RW, 1'b0);
        chk("ign_done_held", oDone, 1'b1);

        // iStart held high after done never retriggers
        run_txn(1'b1, 1'b0, 2, 8'h5A, 8'h5A, 0, lat, pulses, enh, fr, lr);
        chk("hold_latency", lat, 5);
        repeat (10) @(negedge iCLK);
        chk("hold_rw_low", LCD_RW, 1'b0);
        chk("hold_done_held", oDone, 1'b1);
        iStart = 1'b0;

        // iPoll ignored for data reads
        run_txn(1'b1, 1'b1, 0, 8'h80, 8'h80, 0, lat, pulses, enh, fr, lr);
        chk("datapoll_latency", lat, 5);
        chk("datapoll_pulses", pulses, 1);
        chk("datapoll_timeout", oTimeout, 1'b0);

        // Reset while EN is high
        @(negedge iCLK);
        iRS = 1'b1; iPoll = 1'b0; LCD_DATA = 8'h77; iStart = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge iCLK);
            iStart = 1'b0;
            if (LCD_EN) break;
        end
        chk("midrst_en_seen", LCD_EN, 1'b1);
        #2 iRST_N = 1'b0;
        #1;
        chk("midrst_en", LCD_EN, 1'b0);
        chk("midrst_rw", LCD_RW, 1'b0);
        chk("midrst_done", oDone, 1'b0);
        chk("midrst_rs", LCD_RS, 1'b0);
        repeat (2) @(negedge iCLK);
        iRST_N = 1'b1;
        @(negedge iCLK);
        run_txn(1'b1, 1'b0, 0, 8'h3C, 8'h3C, 0, lat, pulses, enh, fr, lr);
        chk("postrst_latency", lat, 5);
        chk("postrst_pulses", pulses, 1);
        chk("postrst_data", oDATA, 8'h3C);

        repeat (3) @(negedge iCLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
